target_port: RTL and testbench
==============================

// Module: target_port
// PURPOSE
// - Bus-side slave endpoint, directly downstream of the initiator port on the serial bus.
// - Deserialises the 16-bit address and 8-bit write data arriving LSB-first.
// - Decodes the address and drives a single-beat parallel request to the local target.
// - Serialises 8-bit read data back onto the bus, then signals completion with a one-cycle ack.
// PARAMETERS
// ADDR_BASE  16'h0000  base address claimed by this target
// ADDR_MASK  16'hF000  decode mask; hit when (addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK)
// PORTS
// clk                 in   1   clock, all logic on posedge
// rst_n               in   1   asynchronous active-low reset
// bus_data_in         in   1   serial bit from initiator, qualified by bus_data_in_valid
// bus_data_in_valid   in   1   bus_data_in carries one bit this cycle
// bus_mode            in   1   1 = data phase, 0 = address phase
// bus_init_rw         in   1   1 = write, 0 = read; sampled with the 16th address bit
// bus_init_ready      in   1   initiator can accept read-data bits this cycle
// bus_data_out        out  1   serial read-data bit, LSB first
// bus_data_out_valid  out  1   bus_data_out valid this cycle
// target_ack          out  1   one-cycle transfer-complete pulse
// addr_hit            out  1   high from decode hit until return to IDLE
// tgt_addr            out  16  latched address to local target
// tgt_wdata           out  8   latched write data
// tgt_write           out  1   one-cycle write strobe
// tgt_read            out  1   one-cycle read strobe
// tgt_rdata           in   8   read data, sampled when tgt_rdata_valid=1
// tgt_rdata_valid     in   1   read data valid
// BEHAVIOUR
// - Reset: state=IDLE; shift regs and bit counters = 0; every output = 0.
// - Outputs are registered; no combinational path from input to output.
// - States: IDLE, ADDR, WDATA, RD_WAIT, RD_TX.
// - Address receive (IDLE/ADDR):
//   - A valid bit with bus_mode=0 in IDLE is stored as addr[0] and moves to ADDR.
//   - Bit k is stored at addr[k]; a 5-bit counter tracks the count.
//   - Cycles without a valid bit hold all state.
// - 16th address bit:
//   - Latch tgt_addr and sample bus_init_rw in the same cycle.
//   - Miss: go to IDLE; no strobe, no ack.
//   - Hit: set addr_hit, then rw=1 -> WDATA; rw=0 -> RD_WAIT with tgt_read=1 for the next cycle only.
// - WDATA:
//   - Valid bits with bus_mode=1 fill wdata[0..7].
//   - On the 8th bit go to IDLE; in the following cycle tgt_write=1, target_ack=1, tgt_wdata stable, addr_hit cleared.
// - RD_WAIT:
//   - tgt_rdata_valid is honoured in every RD_WAIT cycle, including the tgt_read cycle (zero-latency target).
//   - Capture tgt_rdata, then go to RD_TX.
// - RD_TX:
//   - On each cycle with bus_init_ready=1, shift out one bit LSB first; next cycle bus_data_out_valid=1.
//   - bus_init_ready=0 inserts a gap; bus_data_out_valid=0 in the gap; bit index holds.
//   - After the 8th bit: target_ack=1 on the cycle after that bit's valid cycle, then IDLE, addr_hit=0.
// - Protocol error:
//   - Trigger: valid bit with wrong bus_mode (mode=1 in IDLE/ADDR, mode=0 in WDATA).
//   - Action: abort to IDLE, clear counters and addr_hit; no strobe, no ack.
//   - Exception: mode=0 arriving in IDLE begins a new address.
// - Input bits arriving in RD_WAIT/RD_TX are ignored.
// - rst_n low mid-transfer: immediate return to reset values; no partial strobe issued.
// TESTING
// - Write hit: addr 16'h0123, rw=1, data 8'hA5, LSB first, back-to-back
//   -> tgt_write=1, tgt_addr=0123, tgt_wdata=A5, target_ack=1, all in the cycle after the last data bit.
// - Read hit: addr 16'h0040, rw=0, target returns 8'h3C after 3 cycles
//   -> bits 0,0,1,1,1,1,0,0 on bus_data_out with 8 valid pulses, then target_ack one cycle later.
// - Address miss: addr 16'h8000 with ADDR_BASE 0 -> no tgt_write/tgt_read/ack; addr_hit stays 0; next txn accepted.
// - Read backpressure: bus_init_ready toggles 1,0,1,0 -> valid only after ready cycles; 8 bits total, data intact.
// - Protocol error: mode=1 bit after 5 address bits -> IDLE, no strobes; following full write completes normally.
// - Reset mid-read (RD_TX after 3 bits): all outputs 0 at once; a fresh read after reset returns correct data.

Source files
------------

// File: rtl/target_port.sv
// target_port: serial-bus slave endpoint.
// Deserialises address/write data, strobes the local target, serialises read data back.
module target_port #(
    parameter logic [15:0] ADDR_BASE = 16'h0000,
    parameter logic [15:0] ADDR_MASK = 16'hF000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_data_in,
    input  logic        bus_data_in_valid,
    input  logic        bus_mode,
    input  logic        bus_init_rw,
    input  logic        bus_init_ready,
    output logic        bus_data_out,
    output logic        bus_data_out_valid,
    output logic        target_ack,
    output logic        addr_hit,
    output logic [15:0] tgt_addr,
    output logic [7:0]  tgt_wdata,
    output logic        tgt_write,
    output logic        tgt_read,
    input  logic [7:0]  tgt_rdata,
    input  logic        tgt_rdata_valid
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RD_WAIT,
        RD_TX
    } state_t;

    state_t state_q, state_d;

    logic [15:0] addr_q, addr_d, addr_nxt;
    logic [4:0]  acnt_q, acnt_d;
    logic [7:0]  wdata_q, wdata_d, wdata_nxt;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  rcnt_q, rcnt_d;

    logic        dout_d;
    logic        dout_vld_d;
    logic        ack_d;
    logic        hit_d;
    logic        wr_d;
    logic        rd_d;
    logic [15:0] taddr_d;
    logic [7:0]  twdata_d;

    logic        addr_bit;
    logic        data_bit;
    logic        dec_hit;

    assign addr_bit = bus_data_in_valid & ~bus_mode;
    assign data_bit = bus_data_in_valid & bus_mode;

    // Shift-register contents as they will look once the current bit lands.
    always_comb begin
        addr_nxt                = addr_q;
        addr_nxt[acnt_q[3:0]]   = bus_data_in;
        wdata_nxt               = wdata_q;
        wdata_nxt[wcnt_q]       = bus_data_in;
    end

    assign dec_hit = (addr_nxt & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        acnt_d     = acnt_q;
        wdata_d    = wdata_q;
        wcnt_d     = wcnt_q;
        rdata_d    = rdata_q;
        rcnt_d     = rcnt_q;
        dout_d     = bus_data_out;
        dout_vld_d = 1'b0;
        ack_d      = 1'b0;
        hit_d      = addr_hit;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        taddr_d    = tgt_addr;
        twdata_d   = tgt_wdata;

        unique case (state_q)
            IDLE: begin
                if (addr_bit) begin
                    addr_d  = {15'd0, bus_data_in};
                    acnt_d  = 5'd1;
                    state_d = ADDR;
                end else if (data_bit) begin
                    acnt_d = 5'd0;
                    wcnt_d = 3'd0;
                    rcnt_d = 4'd0;
                    hit_d  = 1'b0;
                end
            end

            ADDR: begin
                if (addr_bit) begin
                    addr_d = addr_nxt;
                    if (acnt_q == 5'd15) begin
                        taddr_d = addr_nxt;
                        acnt_d  = 5'd0;
                        if (!dec_hit) begin
                            state_d = IDLE;
                        end else if (bus_init_rw) begin
                            hit_d   = 1'b1;
                            wcnt_d  = 3'd0;
                            state_d = WDATA;
                        end else begin
                            hit_d   = 1'b1;
                            rd_d    = 1'b1;
                            state_d = RD_WAIT;
                        end
                    end else begin
                        acnt_d = acnt_q + 5'd1;
                    end
                end else if (data_bit) begin
                    acnt_d  = 5'd0;
                    wcnt_d  = 3'd0;
                    rcnt_d  = 4'd0;
                    hit_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            WDATA: begin
                if (data_bit) begin
                    wdata_d = wdata_nxt;
                    if (wcnt_q == 3'd7) begin
                        twdata_d = wdata_nxt;
                        wr_d     = 1'b1;
                        ack_d    = 1'b1;
                        hit_d    = 1'b0;
                        wcnt_d   = 3'd0;
                        state_d  = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end else if (addr_bit) begin
                    acnt_d  = 5'd0;
                    wcnt_d  = 3'd0;
                    rcnt_d  = 4'd0;
                    hit_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            // Also live in the strobe cycle so a zero-latency target works.
            RD_WAIT: begin
                if (tgt_rdata_valid) begin
                    rdata_d = tgt_rdata;
                    rcnt_d  = 4'd0;
                    state_d = RD_TX;
                end
            end

            RD_TX: begin
                if (rcnt_q == 4'd8) begin
                    ack_d   = 1'b1;
                    hit_d   = 1'b0;
                    rcnt_d  = 4'd0;
                    state_d = IDLE;
                end else if (bus_init_ready) begin
                    dout_d     = rdata_q[0];
                    dout_vld_d = 1'b1;
                    rdata_d    = {1'b0, rdata_q[7:1]};
                    rcnt_d     = rcnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q             <= 16'd0;
            acnt_q             <= 5'd0;
            wdata_q            <= 8'd0;
            wcnt_q             <= 3'd0;
            rdata_q            <= 8'd0;
            rcnt_q             <= 4'd0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            target_ack         <= 1'b0;
            addr_hit           <= 1'b0;
            tgt_addr           <= 16'd0;
            tgt_wdata          <= 8'd0;
            tgt_write          <= 1'b0;
            tgt_read           <= 1'b0;
        end else begin
            addr_q             <= addr_d;
            acnt_q             <= acnt_d;
            wdata_q            <= wdata_d;
            wcnt_q             <= wcnt_d;
            rdata_q            <= rdata_d;
            rcnt_q             <= rcnt_d;
            bus_data_out       <= dout_d;
            bus_data_out_valid <= dout_vld_d;
            target_ack         <= ack_d;
            addr_hit           <= hit_d;
            tgt_addr           <= taddr_d;
            tgt_wdata          <= twdata_d;
            tgt_write          <= wr_d;
            tgt_read           <= rd_d;
        end
    end

endmodule

// File: tb/tb_target_port.sv
// tb_target_port: directed and randomized transactions against target_port.
// Expected values come from the address-decode rule and transaction-level bookkeeping.
module tb_target_port;

    localparam logic [15:0] BASE = 16'h0000;
    localparam logic [15:0] MASK = 16'hF000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_data_in = 1'b0;
    logic        bus_data_in_valid = 1'b0;
    logic        bus_mode = 1'b0;
    logic        bus_init_rw = 1'b0;
    logic        bus_init_ready = 1'b0;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        target_ack;
    logic        addr_hit;
    logic [15:0] tgt_addr;
    logic [7:0]  tgt_wdata;
    logic        tgt_write;
    logic        tgt_read;
    logic [7:0]  tgt_rdata = 8'd0;
    logic        tgt_rdata_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int n_wr = 0, n_rd = 0, n_ack = 0;
    int e_wr = 0, e_rd = 0, e_ack = 0;
    logic gaps = 1'b0;

    target_port #(
        .ADDR_BASE(BASE),
        .ADDR_MASK(MASK)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus_data_in       (bus_data_in),
        .bus_data_in_valid (bus_data_in_valid),
        .bus_mode          (bus_mode),
        .bus_init_rw       (bus_init_rw),
        .bus_init_ready    (bus_init_ready),
        .bus_data_out      (bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .target_ack        (target_ack),
        .addr_hit          (addr_hit),
        .tgt_addr          (tgt_addr),
        .tgt_wdata         (tgt_wdata),
        .tgt_write         (tgt_write),
        .tgt_read          (tgt_read),
        .tgt_rdata         (tgt_rdata),
        .tgt_rdata_valid   (tgt_rdata_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tgt_write)  n_wr++;
            if (tgt_read)   n_rd++;
            if (target_ack) n_ack++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic hit(logic [15:0] a);
        return (a & MASK) == (BASE & MASK);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        bus_data_in_valid = 1'($urandom);
        bus_mode          = 1'($urandom);
        bus_data_in       = 1'($urandom);
    endtask

    task automatic send_bit(logic b, logic m, logic rw);
        if (gaps && $urandom_range(3) == 0) begin
            repeat ($urandom_range(2, 1)) begin
                bus_data_in_valid = 1'b0;
                bus_mode          = 1'($urandom);
                bus_data_in       = 1'($urandom);
                tick();
            end
        end
        bus_data_in       = b;
        bus_mode          = m;
        bus_init_rw       = rw;
        bus_data_in_valid = 1'b1;
        tick();
    endtask

    task automatic check_counts(string tag);
        check({tag, "_nwr"},  n_wr,  e_wr);
        check({tag, "_nrd"},  n_rd,  e_rd);
        check({tag, "_nack"}, n_ack, e_ack);
    endtask

    task automatic send_addr(logic [15:0] a, logic rw);
        for (int k = 0; k < 16; k++)
            send_bit(a[k], 1'b0, (k == 15) ? rw : 1'($urandom));
        bus_data_in_valid = 1'b0;
        if (hit(a)) begin
            check("addr_hit", 32'(addr_hit), 1);
            check("tgt_addr", 32'(tgt_addr), 32'(a));
            check("tgt_read", 32'(tgt_read), 32'(!rw));
            if (!rw) e_rd++;
        end else begin
            check("miss_hit", 32'(addr_hit), 0);
            check("miss_read", 32'(tgt_read), 0);
        end
    endtask

    task automatic do_write(logic [15:0] a, logic [7:0] d);
        send_addr(a, 1'b1);
        if (hit(a)) begin
            for (int i = 0; i < 8; i++) send_bit(d[i], 1'b1, 1'b0);
            bus_data_in_valid = 1'b0;
            check("tgt_write", 32'(tgt_write), 1);
            check("wr_ack", 32'(target_ack), 1);
            check("tgt_wdata", 32'(tgt_wdata), 32'(d));
            check("wr_addr", 32'(tgt_addr), 32'(a));
            check("wr_hit_clr", 32'(addr_hit), 0);
            e_wr++;
            e_ack++;
            tick();
            check("wr_pulse", 32'({tgt_write, target_ack}), 0);
        end else begin
            repeat (3) tick();
            check("miss_hold", 32'(addr_hit), 0);
        end
        check_counts("wr");
    endtask

    // rmode: 0 always ready, 1 random ready, 2 ready toggling 1,0,1,0...
    task automatic do_read(logic [15:0] a, logic [7:0] d, int lat, int rmode);
        int sent;
        int guard;
        logic r;
        send_addr(a, 1'b0);
        if (!hit(a)) begin
            repeat (3) tick();
            check("miss_hold", 32'(addr_hit), 0);
            check_counts("rdm");
            return;
        end
        bus_init_ready = 1'b1;
        for (int c = 0; c < lat; c++) begin
            tgt_rdata_valid = 1'b0;
            tgt_rdata       = 8'($urandom);
            junk();
            tick();
            check("rd_strobe_1cyc", 32'(tgt_read), 0);
            check("rd_wait_quiet", 32'(bus_data_out_valid), 0);
        end
        tgt_rdata       = d;
        tgt_rdata_valid = 1'b1;
        junk();
        tick();
        tgt_rdata_valid = 1'b0;
        tgt_rdata       = 8'($urandom);
        check("rd_tx_first", 32'(bus_data_out_valid), 0);
        sent  = 0;
        guard = 0;
        while (sent < 8 && guard < 200) begin
            if (rmode == 0)      r = 1'b1;
            else if (rmode == 1) r = 1'($urandom);
            else                 r = (guard % 2 == 0);
            bus_init_ready = r;
            junk();
            tick();
            guard++;
            check("rd_valid", 32'(bus_data_out_valid), 32'(r));
            if (r) begin
                check("rd_bit", 32'(bus_data_out), 32'(d[sent]));
                sent++;
            end
        end
        bus_data_in_valid = 1'b0;
        bus_init_ready    = 1'($urandom);
        check("rd_bits", sent, 8);
        check("rd_ack_early", 32'(target_ack), 0);
        tick();
        check("rd_ack", 32'(target_ack), 1);
        check("rd_hit_clr", 32'(addr_hit), 0);
        check("rd_v_end", 32'(bus_data_out_valid), 0);
        e_ack++;
        tick();
        check("rd_ack_pulse", 32'(target_ack), 0);
        check_counts("rd");
    endtask

    initial begin
        int kind;
        logic [15:0] a;
        logic [7:0] d;
        logic [7:0] rv;

        #12;
        check("reset_outs", 32'({bus_data_out, bus_data_out_valid, target_ack,
              addr_hit, tgt_addr, tgt_wdata, tgt_write, tgt_read}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_write(16'h0123, 8'hA5);
        do_read(16'h0040, 8'h3C, 3, 0);

        do_read(16'h8000, 8'h00, 0, 0);
        do_write(16'h0123, 8'h5A);

        do_read(16'h0ABC, 8'h5A, 1, 2);
        do_read(16'h0FFF, 8'h81, 0, 1);
        do_write(16'h1000, 8'hFF);
        do_write(16'hFFFF, 8'h01);

        a = 16'h0777;
        for (int k = 0; k < 5; k++) send_bit(a[k], 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        bus_data_in_valid = 1'b0;
        check("perr_addr_hit", 32'(addr_hit), 0);
        tick();
        do_write(16'h0246, 8'hC9);

        send_addr(16'h0311, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        bus_data_in_valid = 1'b0;
        check("perr_wd_hit", 32'(addr_hit), 0);
        tick();
        check_counts("perr");
        do_write(16'h0311, 8'h77);

        send_bit(1'b1, 1'b1, 1'b0);
        bus_data_in_valid = 1'b0;
        do_write(16'h0E01, 8'h3D);

        rv = 8'h96;
        send_addr(16'h0040, 1'b0);
        tgt_rdata       = rv;
        tgt_rdata_valid = 1'b1;
        tick();
        tgt_rdata_valid = 1'b0;
        bus_init_ready  = 1'b1;
        repeat (3) tick();
        check("rst_pre_v", 32'(bus_data_out_valid), 1);
        check("rst_pre_b", 32'(bus_data_out), 32'(rv[2]));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 32'({bus_data_out, bus_data_out_valid, target_ack,
              addr_hit, tgt_addr, tgt_wdata, tgt_write, tgt_read}), 0);
        bus_init_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_counts("rst");
        do_read(16'h0040, 8'hC3, 2, 1);

        gaps = 1'b1;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(2));
            a    = 16'($urandom);
            d    = 8'($urandom);
            if (kind != 2) a[15:12] = 4'h0;
            else           a[15:12] = 4'($urandom_range(15, 1));
            if (kind == 0)
                do_write(a, d);
            else if (kind == 1 || $urandom_range(1) == 0)
                do_read(a, d, int'($urandom_range(4)), int'($urandom_range(2)));
            else
                do_write(a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
